// File: rtl/tcp_pkg.sv
// ============================================================================
// tcp_pkg : shared TCP receive-path types, widths and the rx buffer free-space helper
// Rev 1.0
// ============================================================================
`default_nettype none

package tcp_pkg;

    localparam int FLOWID_W         = 4;
    localparam int RX_PAYLOAD_PTR_W = 14;
    localparam int PAYLOAD_ADDR_W   = 32;
    localparam int PAYLOAD_LEN_W    = 16;
    localparam int TCP_FLAG_ACK     = 4;

    localparam logic [RX_PAYLOAD_PTR_W:0] RX_BUF_SIZE = {1'b1, {RX_PAYLOAD_PTR_W{1'b0}}};

    typedef struct packed {
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
    } tcp_pkt_hdr;

    typedef struct packed {
        logic [PAYLOAD_ADDR_W-1:0] addr;
        logic [PAYLOAD_LEN_W-1:0]  len;
    } payload_buf_struct;

    typedef struct packed {
        logic [31:0] ack_num;
    } ack_state_struct;

    typedef struct packed {
        logic [31:0]     their_ack_num;
        ack_state_struct our_ack_state;
    } smol_rx_state_struct;

    typedef struct packed {
        logic [31:0] our_seq_num;
    } smol_tx_state_struct;

    typedef enum logic [1:0] {
        SCHED_NOP   = 2'd0,
        SCHED_SET   = 2'd1,
        SCHED_CLEAR = 2'd2
    } sched_cmd_e;

    typedef struct packed {
        sched_cmd_e cmd;
    } set_clear_struct;

    typedef struct packed {
        logic [FLOWID_W-1:0] flowid;
        set_clear_struct     rt_pend_set_clear;
        set_clear_struct     ack_pend_set_clear;
        set_clear_struct     data_pend_set_clear;
    } sched_cmd_struct;

    // Pointers carry one extra wrap bit so a full buffer is distinguishable from empty.
    function automatic logic [RX_PAYLOAD_PTR_W:0] rx_free_space(
        input logic [RX_PAYLOAD_PTR_W:0] tail,
        input logic [RX_PAYLOAD_PTR_W:0] head
    );
        logic [RX_PAYLOAD_PTR_W:0] used;
        used = tail - head;
        if (used > RX_BUF_SIZE) begin
            return '0;
        end
        return RX_BUF_SIZE - used;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tcp_rx_accept_calc.sv
// ============================================================================
// tcp_rx_accept_calc : combinational ACK / in-order data acceptance and new rx state
// Rev 1.0
// ============================================================================
`default_nettype none

module tcp_rx_accept_calc
    import tcp_pkg::*;
(
    input  logic [31:0]                seq_num,
    input  logic [31:0]                ack_num,
    input  logic                       ack_flag,
    input  logic [PAYLOAD_LEN_W-1:0]   payload_len,
    input  smol_rx_state_struct        rx_state,
    input  smol_tx_state_struct        tx_state,
    input  logic [RX_PAYLOAD_PTR_W:0]  head_ptr,
    output smol_rx_state_struct        new_rx_state,
    output logic                       data_accept,
    output logic                       ack_advance,
    output logic                       ack_pend_set,
    output logic                       state_changed
);

    logic [31:0]               w_ack_delta;
    logic [31:0]               w_ack_window;
    logic [RX_PAYLOAD_PTR_W:0] w_free_space;

    always_comb begin
        w_ack_delta  = ack_num - rx_state.our_ack_state.ack_num;
        w_ack_window = tx_state.our_seq_num - rx_state.our_ack_state.ack_num;
        w_free_space = rx_free_space(rx_state.their_ack_num[RX_PAYLOAD_PTR_W:0], head_ptr);

        // Modular distances make the window test correct across sequence-space wrap.
        ack_advance  = ack_flag && (w_ack_delta != 32'd0) && (w_ack_delta <= w_ack_window);
        data_accept  = (payload_len != '0) &&
                       (seq_num == rx_state.their_ack_num) &&
                       (32'(payload_len) <= 32'(w_free_space));
        ack_pend_set = (payload_len != '0);

        new_rx_state = rx_state;
        if (ack_advance) begin
            new_rx_state.our_ack_state.ack_num = ack_num;
        end
        if (data_accept) begin
            new_rx_state.their_ack_num = rx_state.their_ack_num + 32'(payload_len);
        end
        state_changed = ack_advance | data_accept;
    end

endmodule

`default_nettype wire

// File: rtl/tcp_rx_engine.sv
// ============================================================================
// tcp_rx_engine : per-segment receive engine (state read, accept calc, commit/sched/writeback)
// Rev 1.0
// ============================================================================
`default_nettype none

module tcp_rx_engine
    import tcp_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        rx_pkt_val,
    output logic                        rx_pkt_rdy,
    input  logic [FLOWID_W-1:0]         rx_pkt_flowid,
    input  tcp_pkt_hdr                  rx_pkt_hdr,
    input  payload_buf_struct           rx_pkt_payload,

    output logic [FLOWID_W-1:0]         rx_state_rd_req_addr,
    input  smol_rx_state_struct         rx_state_rd_resp_data,
    input  smol_tx_state_struct         tx_state_rd_resp_data,
    input  logic [RX_PAYLOAD_PTR_W:0]   rx_head_ptr_rd_resp_data,

    output logic                        rx_state_wr_req_val,
    output logic [FLOWID_W-1:0]         rx_state_wr_req_addr,
    output smol_rx_state_struct         rx_state_wr_req_data,

    output logic                        commit_val,
    input  logic                        commit_rdy,
    output payload_buf_struct           commit_desc,
    output logic [RX_PAYLOAD_PTR_W-1:0] commit_dst_addr,

    output logic                        sched_update_val,
    input  logic                        sched_update_rdy,
    output sched_cmd_struct             sched_update_cmd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CALC = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    state_e                      r_state;
    state_e                      w_next_state;

    logic                        r_ready_en;
    logic [FLOWID_W-1:0]         r_flowid;
    tcp_pkt_hdr                  r_hdr;
    payload_buf_struct           r_payload;
    smol_rx_state_struct         r_new_rx_state;
    logic [RX_PAYLOAD_PTR_W-1:0] r_dst_addr;
    sched_cmd_struct             r_sched_cmd;
    logic                        r_wr_pend;
    logic                        r_commit_pend;
    logic                        r_sched_pend;

    smol_rx_state_struct         w_new_rx_state;
    logic                        w_data_accept;
    logic                        w_ack_advance;
    logic                        w_ack_pend_set;
    logic                        w_state_changed;
    logic                        w_commit_done;
    logic                        w_sched_done;
    logic                        w_unused_flags;

    assign w_unused_flags = ^{r_hdr.flags[7:TCP_FLAG_ACK+1], r_hdr.flags[TCP_FLAG_ACK-1:0]};

    tcp_rx_accept_calc u_accept_calc (
        .seq_num       (r_hdr.seq_num),
        .ack_num       (r_hdr.ack_num),
        .ack_flag      (r_hdr.flags[TCP_FLAG_ACK]),
        .payload_len   (r_payload.len),
        .rx_state      (rx_state_rd_resp_data),
        .tx_state      (tx_state_rd_resp_data),
        .head_ptr      (rx_head_ptr_rd_resp_data),
        .new_rx_state  (w_new_rx_state),
        .data_accept   (w_data_accept),
        .ack_advance   (w_ack_advance),
        .ack_pend_set  (w_ack_pend_set),
        .state_changed (w_state_changed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_commit_done = !r_commit_pend || commit_rdy;
        w_sched_done  = !r_sched_pend  || sched_update_rdy;
        w_next_state  = r_state;
        case (r_state)
            ST_IDLE: if (rx_pkt_val && rx_pkt_rdy) w_next_state = ST_RD;
            ST_RD:   w_next_state = ST_CALC;
            ST_CALC: w_next_state = ST_OUT;
            ST_OUT:  if (w_commit_done && w_sched_done) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_pkt_rdy          = (r_state == ST_IDLE) && r_ready_en;
        rx_state_wr_req_val = (r_state == ST_OUT) && r_wr_pend;
        commit_val          = (r_state == ST_OUT) && r_commit_pend;
        sched_update_val    = (r_state == ST_OUT) && r_sched_pend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en     <= 1'b0;
            r_flowid       <= '0;
            r_hdr          <= '0;
            r_payload      <= '0;
            r_new_rx_state <= '0;
            r_dst_addr     <= '0;
            r_sched_cmd    <= '0;
            r_wr_pend      <= 1'b0;
            r_commit_pend  <= 1'b0;
            r_sched_pend   <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if ((r_state == ST_IDLE) && rx_pkt_val && rx_pkt_rdy) begin
                r_flowid  <= rx_pkt_flowid;
                r_hdr     <= rx_pkt_hdr;
                r_payload <= rx_pkt_payload;
            end
            if (r_state == ST_CALC) begin
                r_new_rx_state <= w_new_rx_state;
                r_dst_addr     <= rx_state_rd_resp_data.their_ack_num[RX_PAYLOAD_PTR_W-1:0];
                r_sched_cmd.flowid                  <= r_flowid;
                r_sched_cmd.rt_pend_set_clear.cmd   <= SCHED_NOP;
                r_sched_cmd.ack_pend_set_clear.cmd  <= w_ack_pend_set ? SCHED_SET : SCHED_NOP;
                r_sched_cmd.data_pend_set_clear.cmd <= SCHED_NOP;
                r_wr_pend     <= w_state_changed;
                r_commit_pend <= w_data_accept;
                r_sched_pend  <= w_ack_pend_set | w_ack_advance;
            end
            // Writeback is a single-cycle pulse on OUT entry; the other two wait for their rdy.
            if (r_state == ST_OUT) begin
                r_wr_pend <= 1'b0;
                if (commit_rdy) r_commit_pend <= 1'b0;
                if (sched_update_rdy) r_sched_pend <= 1'b0;
            end
        end
    end

    assign rx_state_rd_req_addr = r_flowid;
    assign rx_state_wr_req_addr = r_flowid;
    assign rx_state_wr_req_data = r_new_rx_state;
    assign commit_desc          = r_payload;
    assign commit_dst_addr      = r_dst_addr;
    assign sched_update_cmd     = r_sched_cmd;

endmodule

`default_nettype wire
